// File: rtl/cu_pkg.sv
// Shared definitions for control_unit: FSM state encoding, instruction classes,
// opcodes, ALU operation codes and IR field positions.
package cu_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_MULDIV, CLS_NOP, CLS_HALT, CLS_ILL
  } instr_cls_t;

  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_AND  = 5'b00011;
  localparam logic [4:0] OP_OR   = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_SHR = 5'b00100;
  localparam logic [4:0] ALU_SHL = 5'b00101;
  localparam logic [4:0] ALU_ROR = 5'b00110;
  localparam logic [4:0] ALU_ROL = 5'b00111;
  localparam logic [4:0] ALU_MUL = 5'b01110;
  localparam logic [4:0] ALU_DIV = 5'b01111;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_LSB = 23;
  localparam int RB_LSB = 19;
  localparam int RC_LSB = 15;

  function automatic instr_cls_t classify(input logic [4:0] op, input bit muldiv_en);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: return CLS_ALU;
      OP_MUL, OP_DIV:                 return muldiv_en ? CLS_MULDIV : CLS_ILL;
      OP_NOP:                         return CLS_NOP;
      OP_HALT:                        return CLS_HALT;
      default:                        return CLS_ILL;
    endcase
  endfunction

  function automatic logic [4:0] alu_code(input logic [4:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_SHR:  return ALU_SHR;
      OP_SHL:  return ALU_SHL;
      OP_ROR:  return ALU_ROR;
      OP_ROL:  return ALU_ROL;
      OP_MUL:  return ALU_MUL;
      OP_DIV:  return ALU_DIV;
      default: return 5'b00000;
    endcase
  endfunction

endpackage

// File: rtl/reg_select.sv
// One-hot general-register decoder: raises bit `field` of `sel` while `en` is high.
module reg_select #(
  parameter int NUM_REGS = 16
) (
  input  logic [3:0]          field,
  input  logic                en,
  output logic [NUM_REGS-1:0] sel
);

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      sel[i] = en && (int'(field) == i);
    end
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control unit sequencing fetch (T0-T2) and execute (T3-T6) for the datapath.
// Build macro CU_MULDIV_EN enables mul/div decode and the T6 state.
//
// state   | meaning
// IDLE    | waiting for Run
// T0      | PC -> MAR, PC+1 -> ZLO
// T1      | memory read, ZLO -> PC on first cycle; holds until Mem_Ready
// T2      | MDR -> IR
// T3      | decode, Rb -> Y
// T4      | Rc on bus, ALU operate into Z
// T5      | ZLO -> Ra (ALU) or ZLO -> LO (mul/div)
// T6      | ZHI -> HI (mul/div only)
// HALT    | stopped until Clear
module control_unit
  import cu_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic                Run,
  input  logic                Mem_Ready,
  input  logic [31:0]         IR_Q,
  output logic                PC_Out,
  output logic                MDR_Out,
  output logic                ZLO_Out,
  output logic                ZHI_Out,
  output logic                PC_In,
  output logic                MDR_In,
  output logic                MAR_In,
  output logic                IR_In,
  output logic                Y_In,
  output logic                ZLO_In,
  output logic                ZHI_In,
  output logic                LO_In,
  output logic                HI_In,
  output logic                IncPC,
  output logic                Read,
  output logic [4:0]          CONTROL,
  output logic [NUM_REGS-1:0] R_In,
  output logic [NUM_REGS-1:0] R_Out,
  output logic                Running,
  output logic                Illegal_Op,
  output logic [31:0]         Instr_Count
);

`ifdef CU_MULDIV_EN
  localparam bit MULDIV_EN = 1'b1;
`else
  localparam bit MULDIV_EN = 1'b0;
`endif

  state_t     state, state_n;
  instr_cls_t cls, dec_cls;
  logic [4:0] op_q;
  logic [3:0] ra_q, rc_q, rin_sel, rout_sel;
  logic       rin_en, rout_en;
  logic       eoi, retire;
  logic       unused_ir;

  assign unused_ir = ^IR_Q[RC_LSB-1:0];
  assign dec_cls   = classify(IR_Q[OP_MSB:OP_LSB], MULDIV_EN);

  always_comb begin
    state_n = state;
    eoi     = 1'b0;
    retire  = 1'b0;
    case (state)
      ST_IDLE: if (Run) state_n = ST_T0;
      ST_T0:   state_n = ST_T1;
      ST_T1:   if (Mem_Ready) state_n = ST_T2;
      ST_T2:   state_n = ST_T3;
      ST_T3: begin
        case (cls)
          CLS_ALU, CLS_MULDIV: state_n = ST_T4;
          CLS_NOP:  begin eoi = 1'b1; retire = 1'b1; end
          CLS_HALT: state_n = ST_HALT;
          default:  eoi = 1'b1;
        endcase
      end
      ST_T4:   state_n = ST_T5;
      ST_T5: begin
        if (cls == CLS_MULDIV) state_n = ST_T6;
        else begin eoi = 1'b1; retire = 1'b1; end
      end
      ST_T6:   begin eoi = 1'b1; retire = 1'b1; end
      ST_HALT: state_n = ST_HALT;
      default: state_n = ST_IDLE;
    endcase
    if (eoi) state_n = Run ? ST_T0 : ST_IDLE;
  end

  // Strobes are registered from the next state so each one is clean for its whole state cycle.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state       <= ST_IDLE;
      cls         <= CLS_NOP;
      op_q        <= '0;
      ra_q        <= '0;
      rc_q        <= '0;
      rin_sel     <= '0;
      rout_sel    <= '0;
      rin_en      <= 1'b0;
      rout_en     <= 1'b0;
      PC_Out      <= 1'b0;
      MDR_Out     <= 1'b0;
      ZLO_Out     <= 1'b0;
      PC_In       <= 1'b0;
      MDR_In      <= 1'b0;
      MAR_In      <= 1'b0;
      IR_In       <= 1'b0;
      Y_In        <= 1'b0;
      ZLO_In      <= 1'b0;
      IncPC       <= 1'b0;
      Read        <= 1'b0;
      CONTROL     <= '0;
      Running     <= 1'b0;
      Illegal_Op  <= 1'b0;
      Instr_Count <= '0;
`ifdef CU_MULDIV_EN
      ZHI_Out     <= 1'b0;
      ZHI_In      <= 1'b0;
      LO_In       <= 1'b0;
      HI_In       <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      Running <= (state_n != ST_IDLE) && (state_n != ST_HALT);
      if (retire) Instr_Count <= Instr_Count + 32'd1;
      if (state == ST_T3 && cls == CLS_ILL) Illegal_Op <= 1'b1;
      if (state == ST_T2) begin
        cls  <= dec_cls;
        op_q <= IR_Q[OP_MSB:OP_LSB];
        ra_q <= IR_Q[RA_LSB +: 4];
        rc_q <= IR_Q[RC_LSB +: 4];
      end

      PC_Out  <= 1'b0;
      MDR_Out <= 1'b0;
      ZLO_Out <= 1'b0;
      PC_In   <= 1'b0;
      MDR_In  <= 1'b0;
      MAR_In  <= 1'b0;
      IR_In   <= 1'b0;
      Y_In    <= 1'b0;
      ZLO_In  <= 1'b0;
      IncPC   <= 1'b0;
      Read    <= 1'b0;
      CONTROL <= '0;
      rin_en  <= 1'b0;
      rout_en <= 1'b0;
`ifdef CU_MULDIV_EN
      ZHI_Out <= 1'b0;
      ZHI_In  <= 1'b0;
      LO_In   <= 1'b0;
      HI_In   <= 1'b0;
`endif

      case (state_n)
        ST_T0: begin
          PC_Out <= 1'b1;
          MAR_In <= 1'b1;
          IncPC  <= 1'b1;
          ZLO_In <= 1'b1;
        end
        ST_T1: begin
          ZLO_Out <= 1'b1;
          PC_In   <= (state != ST_T1);
          Read    <= 1'b1;
          MDR_In  <= 1'b1;
        end
        ST_T2: begin
          MDR_Out <= 1'b1;
          IR_In   <= 1'b1;
        end
        ST_T3: begin
          // The fields are latched on this same edge, so Rb comes straight from IR_Q.
          if (dec_cls == CLS_ALU || dec_cls == CLS_MULDIV) begin
            rout_sel <= IR_Q[RB_LSB +: 4];
            rout_en  <= 1'b1;
            Y_In     <= 1'b1;
          end
        end
        ST_T4: begin
          rout_sel <= rc_q;
          rout_en  <= 1'b1;
          ZLO_In   <= 1'b1;
          CONTROL  <= alu_code(op_q);
`ifdef CU_MULDIV_EN
          if (cls == CLS_MULDIV) ZHI_In <= 1'b1;
`endif
        end
        ST_T5: begin
          ZLO_Out <= 1'b1;
          if (cls == CLS_ALU) begin
            rin_sel <= ra_q;
            rin_en  <= 1'b1;
          end
`ifdef CU_MULDIV_EN
          if (cls == CLS_MULDIV) LO_In <= 1'b1;
`endif
        end
`ifdef CU_MULDIV_EN
        ST_T6: begin
          ZHI_Out <= 1'b1;
          HI_In   <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

`ifndef CU_MULDIV_EN
  assign ZHI_Out = 1'b0;
  assign ZHI_In  = 1'b0;
  assign LO_In   = 1'b0;
  assign HI_In   = 1'b0;
`endif

  reg_select #(.NUM_REGS(NUM_REGS)) u_rin_sel (
    .field (rin_sel),
    .en    (rin_en),
    .sel   (R_In)
  );

  reg_select #(.NUM_REGS(NUM_REGS)) u_rout_sel (
    .field (rout_sel),
    .en    (rout_en),
    .sel   (R_Out)
  );

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: latency table, per-cycle trace model with random
// instruction streams, and directed HALT / Clear / Run-drop sequences.
module tb_control_unit;

  localparam int NR = 16;

  logic          Clock = 1'b0;
  logic          Clear = 1'b1;
  logic          Run = 1'b0;
  logic          Mem_Ready = 1'b1;
  logic [31:0]   IR_Q = '0;
  logic          PC_Out, MDR_Out, ZLO_Out, ZHI_Out;
  logic          PC_In, MDR_In, MAR_In, IR_In, Y_In, ZLO_In, ZHI_In, LO_In, HI_In;
  logic          IncPC, Read, Running, Illegal_Op;
  logic [4:0]    CONTROL;
  logic [NR-1:0] R_In, R_Out;
  logic [31:0]   Instr_Count;

  control_unit #(.NUM_REGS(NR)) dut (
    .Clock(Clock), .Clear(Clear), .Run(Run), .Mem_Ready(Mem_Ready), .IR_Q(IR_Q),
    .PC_Out(PC_Out), .MDR_Out(MDR_Out), .ZLO_Out(ZLO_Out), .ZHI_Out(ZHI_Out),
    .PC_In(PC_In), .MDR_In(MDR_In), .MAR_In(MAR_In), .IR_In(IR_In), .Y_In(Y_In),
    .ZLO_In(ZLO_In), .ZHI_In(ZHI_In), .LO_In(LO_In), .HI_In(HI_In),
    .IncPC(IncPC), .Read(Read), .CONTROL(CONTROL), .R_In(R_In), .R_Out(R_Out),
    .Running(Running), .Illegal_Op(Illegal_Op), .Instr_Count(Instr_Count)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic pc_out, mdr_out, zlo_out, zhi_out;
    logic pc_in, mdr_in, mar_in, ir_in, y_in, zlo_in, zhi_in, lo_in, hi_in;
    logic inc_pc, read;
    logic [4:0] control;
    logic [NR-1:0] r_in, r_out;
    logic running;
  } outs_t;

  typedef struct {
    logic [31:0] ir;
    int          waits;
    int          cycles;
    int          cnt;
    bit          ill;
  } vec_t;

  int          n_tests = 0;
  int          n_fail = 0;
  int unsigned cnt_exp;
  bit          ill_exp;
  outs_t       exp_q[$];
  vec_t        vecs[$];

  function automatic bit muldiv_on();
`ifdef CU_MULDIV_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'd0};
  endfunction

  function automatic outs_t observe();
    outs_t o;
    o = '{pc_out: PC_Out, mdr_out: MDR_Out, zlo_out: ZLO_Out, zhi_out: ZHI_Out,
          pc_in: PC_In, mdr_in: MDR_In, mar_in: MAR_In, ir_in: IR_In, y_in: Y_In,
          zlo_in: ZLO_In, zhi_in: ZHI_In, lo_in: LO_In, hi_in: HI_In,
          inc_pc: IncPC, read: Read, control: CONTROL, r_in: R_In, r_out: R_Out,
          running: Running};
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Expected output for every cycle of one instruction, written from the phase descriptions.
  task automatic build_trace(input logic [31:0] ir, input int waits,
                             output bit retires, output bit illegal);
    logic [4:0] op;
    int         ra, rb, rc;
    bit         is_alu, is_md;
    outs_t      o;
    op = ir[31:27];
    ra = int'(ir[26:23]);
    rb = int'(ir[22:19]);
    rc = int'(ir[18:15]);
    is_alu = (op >= 5'd1) && (op <= 5'd8);
    is_md  = ((op == 5'd15) || (op == 5'd16)) && muldiv_on();
    exp_q.delete();
    o = '0; o.running = 1; o.pc_out = 1; o.mar_in = 1; o.inc_pc = 1; o.zlo_in = 1;
    exp_q.push_back(o);
    for (int w = 0; w <= waits; w++) begin
      o = '0; o.running = 1; o.zlo_out = 1; o.read = 1; o.mdr_in = 1; o.pc_in = (w == 0);
      exp_q.push_back(o);
    end
    o = '0; o.running = 1; o.mdr_out = 1; o.ir_in = 1;
    exp_q.push_back(o);
    o = '0; o.running = 1;
    if (is_alu || is_md) begin o.r_out = NR'(1) << rb; o.y_in = 1; end
    exp_q.push_back(o);
    if (is_alu) begin
      o = '0; o.running = 1; o.r_out = NR'(1) << rc; o.zlo_in = 1; o.control = op - 5'd1;
      exp_q.push_back(o);
      o = '0; o.running = 1; o.zlo_out = 1; o.r_in = NR'(1) << ra;
      exp_q.push_back(o);
    end
    if (is_md) begin
      o = '0; o.running = 1; o.r_out = NR'(1) << rc; o.zlo_in = 1; o.zhi_in = 1;
      o.control = (op == 5'd15) ? 5'd14 : 5'd15;
      exp_q.push_back(o);
      o = '0; o.running = 1; o.zlo_out = 1; o.lo_in = 1;
      exp_q.push_back(o);
      o = '0; o.running = 1; o.zhi_out = 1; o.hi_in = 1;
      exp_q.push_back(o);
    end
    retires = is_alu || is_md || (op == 5'd25);
    illegal = !(is_alu || is_md || (op == 5'd25) || (op == 5'd26));
  endtask

  task automatic do_reset();
    Clear = 1'b1; Run = 1'b0; Mem_Ready = 1'b1; IR_Q = '0;
    #2;
    check("reset_outs", observe(), '0);
    check("reset_count", Instr_Count, 0);
    check("reset_illegal", Illegal_Op, 0);
    @(posedge Clock); #1;
    Clear = 1'b0;
    cnt_exp = 0;
    ill_exp = 1'b0;
  endtask

  // drop_at: trace index after which Run falls; beyond the trace length Run stays high.
  task automatic run_instr(input logic [31:0] ir, input int waits, input int drop_at);
    bit ret, ill;
    build_trace(ir, waits, ret, ill);
    IR_Q = ir;
    Run  = 1'b1;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge Clock); #1;
      check($sformatf("trace op%0d c%0d", ir[31:27], k), observe(), exp_q[k]);
      if (k == 0) begin
        check("count_at_T0", Instr_Count, cnt_exp);
        check("illegal_at_T0", Illegal_Op, ill_exp);
      end
      if (k == drop_at) Run = 1'b0;
      Mem_Ready = (k >= 1 && k <= waits) ? 1'b0 : 1'b1;
    end
    if (ret) cnt_exp++;
    if (ill) ill_exp = 1'b1;
    if (!Run) begin
      @(posedge Clock); #1;
      check("idle_after", observe(), '0);
      check("count_after", Instr_Count, cnt_exp);
      check("illegal_after", Illegal_Op, ill_exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int        idx, pulses;
    bit        done;
    logic [4:0] op;
    logic [4:0] legal[11];
    legal = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd15, 5'd16, 5'd25};

    // Latency table: {IR, Mem_Ready-low cycles, cycles running, count delta, illegal}
    vecs.push_back('{mk_ir(5'd1, 4'd1, 4'd2, 4'd3), 0, 6, 1, 1'b0});
    vecs.push_back('{32'h32920000, 0, 6, 1, 1'b0});
    vecs.push_back('{32'h32920000, 3, 9, 1, 1'b0});
    vecs.push_back('{mk_ir(5'd8, 4'd15, 4'd0, 4'd7), 1, 7, 1, 1'b0});
    vecs.push_back('{mk_ir(5'd25, 4'd0, 4'd0, 4'd0), 0, 4, 1, 1'b0});
    vecs.push_back('{mk_ir(5'd25, 4'd0, 4'd0, 4'd0), 2, 6, 1, 1'b0});
    vecs.push_back('{mk_ir(5'd0, 4'd1, 4'd1, 4'd1), 0, 4, 0, 1'b1});
    vecs.push_back('{mk_ir(5'd31, 4'd1, 4'd1, 4'd1), 0, 4, 0, 1'b1});
    vecs.push_back('{mk_ir(5'd26, 4'd0, 4'd0, 4'd0), 0, 4, 0, 1'b0});
`ifdef CU_MULDIV_EN
    vecs.push_back('{32'h78000000, 0, 7, 1, 1'b0});
    vecs.push_back('{mk_ir(5'd16, 4'd2, 4'd3, 4'd4), 1, 8, 1, 1'b0});
`else
    vecs.push_back('{32'h78000000, 0, 4, 0, 1'b1});
    vecs.push_back('{mk_ir(5'd16, 4'd2, 4'd3, 4'd4), 1, 5, 0, 1'b1});
`endif

    foreach (vecs[i]) begin
      do_reset();
      IR_Q = vecs[i].ir;
      Run  = 1'b1;
      idx = 0; pulses = 0; done = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
        @(posedge Clock); #1;
        if (!Running) done = 1'b1;
        else begin
          if (PC_In) pulses++;
          Run = 1'b0;
          Mem_Ready = (idx >= 1 && idx <= vecs[i].waits) ? 1'b0 : 1'b1;
          idx++;
        end
      end
      check($sformatf("vec%0d_done", i), done, 1);
      check($sformatf("vec%0d_cycles", i), idx, vecs[i].cycles);
      check($sformatf("vec%0d_count", i), Instr_Count, vecs[i].cnt);
      check($sformatf("vec%0d_illegal", i), Illegal_Op, vecs[i].ill);
      check($sformatf("vec%0d_pc_in_pulses", i), pulses, 1);
    end

    // Directed traces: shl example, stretched fetch, mul, and Run dropped in T4 of an add.
    do_reset();
    run_instr(32'h32920000, 0, 0);
    run_instr(32'h32920000, 3, 2);
    run_instr(32'h78000000, 0, 1);
    run_instr(mk_ir(5'd1, 4'd9, 4'd10, 4'd11), 0, 4);

    // Random instruction streams, mixing back-to-back and Run-dropped instructions.
    do_reset();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) != 0) op = legal[$urandom_range(0, 10)];
      else op = 5'($urandom_range(0, 31));
      if (op == 5'd26) op = 5'd25;
      run_instr({op, 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)},
                $urandom_range(0, 3), (n == 39) ? 0 : $urandom_range(0, 9));
    end

    // HALT holds with Run high until Clear.
    do_reset();
    run_instr(mk_ir(5'd26, 4'd0, 4'd0, 4'd0), 0, 99);
    for (int c = 0; c < 20; c++) begin
      @(posedge Clock); #1;
      check($sformatf("halt_outs c%0d", c), observe(), '0);
      check($sformatf("halt_count c%0d", c), Instr_Count, 0);
    end
    do_reset();
    run_instr(mk_ir(5'd2, 4'd3, 4'd4, 4'd5), 0, 0);

    // Clear in T4 of the second back-to-back add aborts it and zeroes the count.
    do_reset();
    run_instr(mk_ir(5'd1, 4'd1, 4'd2, 4'd6), 0, 99);
    IR_Q = mk_ir(5'd1, 4'd1, 4'd2, 4'd6);
    for (int k = 0; k < 5; k++) begin
      @(posedge Clock); #1;
    end
    check("abort_T4_rout", R_Out, 16'h0040);
    check("abort_count_before", Instr_Count, 1);
    Clear = 1'b1;
    #1;
    check("abort_outs", observe(), '0);
    check("abort_count", Instr_Count, 0);
    check("abort_illegal", Illegal_Op, 0);
    #2;
    Clear = 1'b0;
    Run = 1'b0;
    @(posedge Clock); #1;
    check("abort_idle", observe(), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
